// File: rtl/cargador_bloque.sv
// Header loader and search sequencer for the proof-of-work unit.
// Collects NUM_BYTES header bytes over a valid/ready port, starts the search
// unit, bounds the search with a cycle timeout, and holds the result on a
// valid/ack port until the consumer takes it.
module cargador_bloque #(
  parameter int NUM_BYTES      = 12,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic [7:0]             target_in,
  output logic [8*NUM_BYTES-1:0] bloque_bytes,
  output logic [7:0]             target,
  output logic                   inicio,
  input  logic                   terminado,
  input  logic [23:0]            hash,
  output logic                   res_valid,
  output logic [23:0]            res_hash,
  output logic [CNT_W-1:0]       res_ciclos,
  output logic                   res_timeout,
  input  logic                   res_ack
);

  // state     | meaning
  // CARGA     | accepting header bytes, byte_ready high
  // ARRANQUE  | one cycle: inicio raised, search pipeline filling, terminado ignored
  // BUSCA     | search running, cycle counter advancing, watching terminado/timeout
  // RESULTADO | result held on res_*, waiting for res_ack

  localparam int                BW         = 8 * NUM_BYTES;
  localparam int                BC_W       = $clog2(NUM_BYTES + 1);
  localparam logic [BC_W-1:0]   LAST_BYTE  = BC_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    CARGA     = 2'd0,
    ARRANQUE  = 2'd1,
    BUSCA     = 2'd2,
    RESULTADO = 2'd3
  } state_t;

  state_t            state;
  logic [BC_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]  ciclos;

  // Ready is decoded from the state but forced low while reset is held, so
  // the upstream source never sees a ready during reset.
  assign byte_ready = (state == CARGA) && !reset;

  // Sequencer: state, header assembly, search cycle counter and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= CARGA;
      byte_cnt     <= '0;
      ciclos       <= '0;
      bloque_bytes <= '0;
      target       <= '0;
      inicio       <= 1'b0;
      res_valid    <= 1'b0;
      res_hash     <= '0;
      res_ciclos   <= '0;
      res_timeout  <= 1'b0;
    end else begin
      case (state)
        CARGA: begin
          // byte_ready is high throughout CARGA, so a handshake is byte_valid.
          if (byte_valid) begin
            bloque_bytes <= {bloque_bytes[BW-9:0], byte_in};
            if (byte_cnt == LAST_BYTE) begin
              target   <= target_in;
              byte_cnt <= '0;
              inicio   <= 1'b1;
              state    <= ARRANQUE;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end

        ARRANQUE: begin
          ciclos <= '0;
          state  <= BUSCA;
        end

        BUSCA: begin
          // A hit on the last allowed cycle is reported as a hit, not a timeout.
          if (terminado) begin
            res_hash    <= hash;
            res_ciclos  <= ciclos;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            inicio      <= 1'b0;
            state       <= RESULTADO;
          end else if (ciclos == LAST_CYCLE) begin
            res_hash    <= hash;
            res_ciclos  <= ciclos;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            inicio      <= 1'b0;
            state       <= RESULTADO;
          end else begin
            ciclos <= ciclos + CNT_W'(1);
          end
        end

        RESULTADO: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= CARGA;
          end
        end

        default: begin
          state <= CARGA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cargador_bloque.sv
// Self-checking bench for cargador_bloque with a short timeout (16 cycles).
module tb_cargador_bloque;

  localparam int NB    = 12;
  localparam int CW    = 24;
  localparam int TOUT  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic [7:0]      target_in;
  logic [8*NB-1:0] bloque_bytes;
  logic [7:0]      target;
  logic            inicio;
  logic            terminado;
  logic [23:0]     hash;
  logic            res_valid;
  logic [23:0]     res_hash;
  logic [CW-1:0]   res_ciclos;
  logic            res_timeout;
  logic            res_ack;

  cargador_bloque #(.NUM_BYTES(NB), .CNT_W(CW), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .target_in    (target_in),
    .bloque_bytes (bloque_bytes),
    .target       (target),
    .inicio       (inicio),
    .terminado    (terminado),
    .hash         (hash),
    .res_valid    (res_valid),
    .res_hash     (res_hash),
    .res_ciclos   (res_ciclos),
    .res_timeout  (res_timeout),
    .res_ack      (res_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  seed;
    logic [7:0]  tgt;
    bit          gap;
    bit          ack_in_load;
    int          term_at;
    logic [23:0] base;
    int          ack_delay;
    logic [95:0] exp_bloque;
    logic [23:0] exp_hash;
    logic [23:0] exp_ciclos;
    bit          exp_to;
  } vec_t;

  typedef struct {
    logic [23:0] h;
    logic [23:0] c;
    bit          to;
  } res_t;

  vec_t vecs[4];
  res_t sb[$];
  res_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loads NB bytes seed, seed+1, ...; with gap, an idle cycle with junk on
  // byte_in precedes every byte after the first. Starts and ends at a negedge.
  task automatic load_hdr(input logic [7:0] seed, input logic [7:0] tgt, input bit gap);
    for (int i = 0; i < NB; i++) begin
      if (gap && i > 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'hEE;
        target_in  = 8'h77;
        @(posedge clk); @(negedge clk);
      end
      if (i == 0) chk("ready_in_carga", byte_ready, 1'b1);
      if (i == NB - 1) chk("no_early_start", inicio, 1'b0);
      byte_valid = 1'b1;
      byte_in    = seed + 8'(i);
      target_in  = (i == NB - 1) ? tgt : 8'h77;
      @(posedge clk); @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_in    = 8'hEE;
    target_in  = 8'h77;
  endtask

  // Called at the negedge in ARRANQUE. hash = base + k in BUSCA cycle k;
  // terminado raised in cycle term_at (never if term_at >= TOUT).
  task automatic run_search(input int term_at, input logic [23:0] base);
    terminado = 1'b1;       // must be ignored in ARRANQUE
    hash      = '1;
    for (int k = 0; k < TOUT; k++) begin
      @(posedge clk); @(negedge clk);
      chk("inicio_in_busca", inicio, 1'b1);
      chk("no_early_result", res_valid, 1'b0);
      hash      = base + 24'(k);
      terminado = (k == term_at);
      if (k == term_at) break;
    end
    @(posedge clk); @(negedge clk);
    terminado = 1'b0;
    hash      = 24'h5A5A5A;
  endtask

  task automatic check_result();
    chk("res_valid", res_valid, 1'b1);
    chk("inicio_off", inicio, 1'b0);
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("res_hash", res_hash, cur.h);
      chk("res_ciclos", res_ciclos, cur.c);
      chk("res_timeout", res_timeout, cur.to);
    end else begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end
  endtask

  // Holds res_ack low for n cycles (result must stay put), then acks.
  task automatic do_ack(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_hash", res_hash, cur.h);
      chk("hold_ciclos", res_ciclos, cur.c);
      chk("hold_timeout", res_timeout, cur.to);
      chk("hold_not_ready", byte_ready, 1'b0);
    end
    res_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ack = 1'b0;
    chk("ack_valid_low", res_valid, 1'b0);
    chk("ack_ready_high", byte_ready, 1'b1);
    chk("ack_inicio_low", inicio, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h10, 1'b0, 1'b0, 4,  24'h000AB8, 3,
                96'h0102_0304_0506_0708_090A_0B0C, 24'h000ABC, 24'd4,  1'b0};
    vecs[1] = '{8'h21, 8'h3C, 1'b1, 1'b1, 99, 24'h100000, 0,
                96'h2122_2324_2526_2728_292A_2B2C, 24'h10000F, 24'd15, 1'b1};
    vecs[2] = '{8'hF0, 8'hA5, 1'b1, 1'b0, 15, 24'h200000, 1,
                96'hF0F1_F2F3_F4F5_F6F7_F8F9_FAFB, 24'h20000F, 24'd15, 1'b0};
    vecs[3] = '{8'h50, 8'h01, 1'b0, 1'b0, 0,  24'h3000AA, 2,
                96'h5051_5253_5455_5657_5859_5A5B, 24'h3000AA, 24'd0,  1'b0};

    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    target_in  = 8'h00;
    terminado  = 1'b0;
    hash       = 24'h0;
    res_ack    = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_inicio", inicio, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_bloque", bloque_bytes, 96'h0);
    chk("rst_target", target, 8'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", byte_ready, 1'b1);
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      res_ack = vecs[v].ack_in_load;
      load_hdr(vecs[v].seed, vecs[v].tgt, vecs[v].gap);
      res_ack = 1'b0;
      chk("bloque", bloque_bytes, vecs[v].exp_bloque);
      chk("target", target, vecs[v].tgt);
      chk("inicio_arranque", inicio, 1'b1);
      chk("ready_arranque", byte_ready, 1'b0);
      sb.push_back('{vecs[v].exp_hash, vecs[v].exp_ciclos, vecs[v].exp_to});
      run_search(vecs[v].term_at, vecs[v].base);
      check_result();
      chk("bloque_stable", bloque_bytes, vecs[v].exp_bloque);
      chk("target_stable", target, vecs[v].tgt);
      do_ack(vecs[v].ack_delay);
    end

    // Reset in the middle of BUSCA.
    load_hdr(8'h40, 8'h22, 1'b0);
    chk("bloque_pre_rst", bloque_bytes, 96'h4041_4243_4445_4647_4849_4A4B);
    terminado = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("inicio_before_rst", inicio, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_inicio", inicio, 1'b0);
    chk("midrst_bloque", bloque_bytes, 96'h0);
    chk("midrst_target", target, 8'h0);
    chk("midrst_ready", byte_ready, 1'b0);
    chk("midrst_valid", res_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", byte_ready, 1'b1);
    @(negedge clk);

    // Reset after 5 bytes: the partial header must be discarded.
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'hC0 + 8'(i);
      @(posedge clk); @(negedge clk);
      chk("partial_inicio_low", inicio, 1'b0);
    end
    byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("partial_rst_bloque", bloque_bytes, 96'h0);
    reset = 1'b0;
    @(negedge clk);
    load_hdr(8'h60, 8'h99, 1'b0);
    chk("reload_bloque", bloque_bytes, 96'h6061_6263_6465_6667_6869_6A6B);
    chk("reload_target", target, 8'h99);
    chk("reload_inicio", inicio, 1'b1);
    sb.push_back('{24'h700002, 24'd2, 1'b0});
    run_search(2, 24'h700000);
    check_result();
    do_ack(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
